// File: rtl/fifo_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding and a
// pointer-width helper.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } wr_state_e;

    // Width of a writer index; at least one bit so the pointer is never zero-width.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin search: first set req bit at or above rr_ptr, wrapping at NREQ-1.
// Purely combinational; winner is one-hot (all zeros when valid is low).
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   rr_ptr,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    always_comb begin
        // NOTE: every output gets a default before the search so no latch is inferred.
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!valid && req[(int'(rr_ptr) + k) % NREQ]) begin
                winner[(int'(rr_ptr) + k) % NREQ] = 1'b1;
                valid                             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ writers.
// Define FIFO_WR_ARB_BURST_EN to keep a grant for up to MAX_BURST consecutive pushes.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int DEEP      = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic             Full,
    output logic [NREQ-1:0]  grant,
    output logic             push,
    output logic [DW-1:0]    push_data,
    output logic [DEEP-1:0]  address
);

    localparam int PW = ptr_w(NREQ);

    wr_state_e       state_q, state_d;
    logic [NREQ-1:0] grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   gnt_idx, ptr_after, arb_ptr;
    logic [DEEP-1:0] address_d;
    logic            req_gnt;
    logic [NREQ-1:0] win;
    logic            win_valid;
    logic            rearb;
    logic            burst_done;

    always_comb begin
        gnt_idx   = '0;
        push_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                gnt_idx   = PW'(i);
                push_data = wdata[i*DW +: DW];
            end
        end
    end

    assign req_gnt   = |(req & grant);
    assign push      = rst_n & (state_q == GRANT) & req_gnt & ~Full;
    assign ptr_after = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    // A push re-arbitrates from the writer after the one just served.
    assign arb_ptr   = push ? ptr_after : rr_ptr_q;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (arb_ptr),
        .winner (win),
        .valid  (win_valid)
    );

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] burst_q, burst_d;

    assign burst_done = (burst_q == BW'(MAX_BURST - 1));

    always_comb begin
        burst_d = burst_q;
        if (rearb)     burst_d = '0;
        else if (push) burst_d = burst_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) burst_q <= '0;
        else        burst_q <= burst_d;
    end
`else
    assign burst_done = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        rr_ptr_d  = rr_ptr_q;
        address_d = address;
        rearb     = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req && !Full) rearb = 1'b1;
            end
            GRANT: begin
                if (Full) begin
                    state_d = STALL;
                end else if (req_gnt) begin
                    address_d = address + 1'b1;
                    rr_ptr_d  = ptr_after;
                    if (burst_done) rearb = 1'b1;
                end else begin
                    rearb = 1'b1;
                end
            end
            STALL: begin
                if (!Full) begin
                    if (req_gnt) state_d = GRANT;
                    else         rearb   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        if (rearb) begin
            state_d = win_valid ? GRANT : IDLE;
            grant_d = win;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q  <= IDLE;
            grant    <= '0;
            rr_ptr_q <= '0;
            address  <= '0;
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            address  <= address_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed phases plus random traffic,
// compared each cycle against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int DEEP = 3;
    localparam int MAXB = 4;
`ifdef FIFO_WR_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] wdata;
    logic              Full;
    logic [NREQ-1:0]   grant;
    logic              push;
    logic [DW-1:0]     push_data;
    logic [DEEP-1:0]   address;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .DEEP      (DEEP),
        .MAX_BURST (MAXB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .wdata     (wdata),
        .Full      (Full),
        .grant     (grant),
        .push      (push),
        .push_data (push_data),
        .address   (address)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: current owner (-1 = none), whether it is stalled, pointer, address, burst count.
    int m_owner, m_stall, m_ptr, m_addr, m_cnt;
    int n_vec, n_mis;

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic [NREQ-1:0] r, input logic f, input logic rn, input bit chk);
        logic [NREQ-1:0] e_grant;
        logic            e_push;
        logic [DW-1:0]   e_data;
        @(negedge clk);
        req   = r;
        Full  = f;
        rst_n = rn;
        wdata = $urandom;
        #1;
        if (chk) begin
            e_grant = (m_owner < 0) ? '0 : NREQ'(1 << m_owner);
            e_push  = rn && (m_owner >= 0) && (m_stall == 0) && r[m_owner] && !f;
            e_data  = (m_owner < 0) ? '0 : wdata[m_owner*DW +: DW];
            check("grant",     32'(grant),     32'(e_grant));
            check("push",      32'(push),      32'(e_push));
            check("push_data", 32'(push_data), 32'(e_data));
            check("address",   32'(address),   32'(m_addr));
        end
        if (!rn) begin
            m_owner = -1; m_stall = 0; m_ptr = 0; m_addr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            if (r != '0 && !f) begin
                m_owner = pick(r, m_ptr);
                m_cnt   = 0;
            end
        end else if (m_stall != 0) begin
            if (!f) begin
                m_stall = 0;
                if (!r[m_owner]) begin
                    m_owner = pick(r, m_ptr);
                    m_cnt   = 0;
                end
            end
        end else if (f) begin
            m_stall = 1;
        end else if (r[m_owner]) begin
            m_addr = (m_addr + 1) % (1 << DEEP);
            m_ptr  = (m_owner + 1) % NREQ;
            m_cnt++;
            if (!BURST || m_cnt == MAXB) begin
                m_owner = pick(r, m_ptr);
                m_cnt   = 0;
            end
        end else begin
            m_owner = pick(r, m_ptr);
            m_cnt   = 0;
        end
    endtask

    initial begin
        n_vec = 0; n_mis = 0;
        m_owner = -1; m_stall = 0; m_ptr = 0; m_addr = 0; m_cnt = 0;
        req = '0; Full = 1'b0; rst_n = 1'b0; wdata = '0;

        // Reset held two cycles with every writer requesting.
        step(4'b1111, 1'b0, 1'b0, 1'b0);
        step(4'b1111, 1'b0, 1'b0, 1'b1);
        // Rotation under full load; runs past address 7 so the wrap is exercised.
        for (int i = 0; i < 12; i++) step(4'b1111, 1'b0, 1'b1, 1'b1);

        // Stall while writer 2 holds the grant, then release.
        step(4'b0000, 1'b0, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b1);
        step(4'b0100, 1'b0, 1'b1, 1'b1);
        step(4'b0100, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, 1'b1, 1'b1);

        // Writer 1 drops its request while stalled; grant must move on without a push.
        step(4'b0000, 1'b1, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b1);
        step(4'b0010, 1'b0, 1'b1, 1'b1);
        step(4'b0110, 1'b1, 1'b1, 1'b1);
        step(4'b0110, 1'b1, 1'b1, 1'b1);
        step(4'b0100, 1'b1, 1'b1, 1'b1);
        step(4'b0100, 1'b0, 1'b1, 1'b1);
        step(4'b0100, 1'b0, 1'b1, 1'b1);
        step(4'b0000, 1'b0, 1'b1, 1'b1);

        // Two writers contending: bursts of MAXB when compiled in, alternation otherwise.
        for (int i = 0; i < 12; i++) step(4'b0011, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of a grant.
        step(4'b1111, 1'b0, 1'b1, 1'b1);
        step(4'b1111, 1'b0, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b1, 1'b1);

        // Random traffic with occasional Full and rare resets.
        for (int i = 0; i < 400; i++) begin
            step(NREQ'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 99) != 0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning the number of writers sharing the FIFO write port (2..8).
REQ-002 SHALL have parameter DW, default 8, meaning the write data width in bits.
REQ-003 SHALL have parameter DEEP, default 8, meaning the write-address width in bits (the memory holds 2^DEEP words).
REQ-004 SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive pushes per grant when burst mode is compiled in.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port req, input, NREQ bits: per-writer write request, level, held until served.
REQ-008 SHALL have port wdata, input, NREQ*DW bits: per-writer data; writer i occupies bits [i*DW +: DW].
REQ-009 SHALL have port Full, input, 1 bit: FIFO full flag from the read/compare side.
REQ-010 SHALL have port grant, output, NREQ bits: registered one-hot grant, or all zeros.
REQ-011 SHALL have port push, output, 1 bit: FIFO write strobe; one word is written per cycle while it is high.
REQ-012 SHALL have port push_data, output, DW bits: the wdata slice of the granted writer.
REQ-013 SHALL have port address, output, DEEP bits: registered FIFO write address.

Function
REQ-014 SHALL implement a state machine with three states: IDLE, GRANT, STALL.
REQ-015 SHALL, in IDLE with |req and !Full, pick the round-robin winner and enter GRANT next cycle with grant[winner]=1.
REQ-016 SHALL pick the winner as the first set req bit searching upward from the pointer rr_ptr, wrapping at NREQ-1 -> 0.
REQ-017 SHALL drive push = (state==GRANT) & req[granted] & !Full, combinationally.
REQ-018 SHALL drive push_data = the wdata slice of the granted writer; it SHALL be 0 when grant==0.
REQ-019 SHALL increment address by 1 on every cycle with push=1, wrapping from 2^DEEP-1 to 0; address SHALL otherwise hold.
REQ-020 SHALL, on a push from writer w, set rr_ptr to (w+1) mod NREQ.
REQ-021 SHALL, after a push in GRANT without burst mode, re-arbitrate in the same edge: GRANT with the new winner if any req is set (excluding the just-served writer only if another writer requests), else IDLE with grant=0.
REQ-022 SHALL move GRANT -> STALL when Full=1, keeping grant unchanged and push=0.
REQ-023 SHALL move STALL -> GRANT when Full=0 and req[granted]=1; when Full=0 and req[granted]=0, it SHALL re-arbitrate as in REQ-015.
REQ-024 SHALL, in GRANT when req[granted] drops without a push, re-arbitrate next cycle without moving rr_ptr.
REQ-025 SHALL never assert more than one grant bit, and SHALL never push while Full=1.
REQ-026 SHALL, in IDLE when Full=1, stay in IDLE with grant=0 regardless of req.

Reset
REQ-027 SHALL, when rst_n=0 at a clk edge, set state=IDLE, grant=0, address=0, rr_ptr=0 and burst count=0; push and push_data SHALL then be 0 from that edge on.
REQ-028 SHALL let a reset in the middle of GRANT or STALL abort the grant with no push on that edge.

Configuration
REQ-029 SHALL, with macro FIFO_WR_ARB_BURST_EN defined, keep the grant across consecutive pushes while req[granted] stays high, up to MAX_BURST pushes, then force re-arbitration with rr_ptr=granted+1; the burst counter SHALL hold in STALL.
REQ-030 SHALL, without FIFO_WR_ARB_BURST_EN, grant exactly one push per arbitration (REQ-021), with no burst counter logic.

Structure
REQ-031 SHALL place the state encoding (IDLE=0, GRANT=1, STALL=2; 2-bit type) in the shared package fifo_pkg.
REQ-032 SHALL implement the round-robin search as one combinational sub-module, rr_pick (inputs req and rr_ptr; outputs a one-hot winner and a valid flag).

Verification
REQ-033 SHALL check reset: rst_n=0 for 2 cycles with req=4'b1111 -> grant=0, push=0, address=0.
REQ-034 SHALL check rotation: NREQ=4, req=4'b1111 held, Full=0, no burst -> grant sequence 0001,0010,0100,1000,0001; address increments 0..4.
REQ-035 SHALL check stall: Full=1 for 3 cycles during GRANT of writer 2 -> push=0, grant stays 0100, address holds; Full=0 -> push=1 next cycle with push_data=wdata[23:16].
REQ-036 SHALL check wrap: DEEP=3, 9 single pushes -> address goes 7 -> 0 -> 1.
REQ-037 SHALL check burst: FIFO_WR_ARB_BURST_EN with MAX_BURST=4 and req=4'b0011 -> writer 0 pushes 4, then writer 1 pushes 4.
REQ-038 SHALL check drop: writer 1 deasserts req while in STALL, then Full=0 -> grant moves to the next requester, and writer 1 gets no push.
